// File: rtl/sdram_copy_dma.sv
// sdram_copy_dma: SDRAM-to-SDRAM copy engine on the arbiter's DMA port.
// Reads up to FIFO_DEPTH words into a local FIFO, then writes them back to the
// destination, alternating read and write bursts until the length is consumed.
//
// Request handshake: the engine raises dma_req_valid together with addr/rw/wdata
// from registers and holds all of them stable until the arbiter pulses
// dma_req_ack while valid is high. That ack edge completes the request (read
// data is taken in the same cycle). valid is then low for one cycle before the
// next request, and ack seen while valid is low is ignored.
module sdram_copy_dma #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [22:0]      cfg_src,
    input  logic [22:0]      cfg_dst,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] words_done,
    output logic             dma_req_valid,
    output logic [22:0]      dma_req_addr,
    output logic             dma_req_rw,
    output logic [31:0]      dma_req_wdata,
    input  logic             dma_req_ack,
    input  logic [31:0]      dma_rsp_rdata
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [22:0]      r_rd_ptr;
    logic [22:0]      r_wr_ptr;
    logic [LEN_W-1:0] r_rd_left;
    logic [LEN_W-1:0] r_wr_left;
    logic [LEN_W-1:0] r_words_done;

    logic [31:0]      r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             r_valid;
    logic [22:0]      r_addr;
    logic             r_rw;
    logic [31:0]      r_wdata;

    logic w_ack;
    logic w_start;
    logic w_push;
    logic w_pop;
    logic w_issue;

    assign w_ack   = r_valid & dma_req_ack;
    assign w_start = (r_state == S_IDLE) & cfg_start;
    assign w_push  = (r_state == S_READ) & w_ack;
    assign w_pop   = (r_state == S_WRITE) & w_ack;
    // A request is (re)issued one cycle after the previous ack, whenever valid is low.
    assign w_issue = ((r_state == S_READ) || (r_state == S_WRITE)) & ~r_valid;

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign words_done    = r_words_done;
    assign dma_req_valid = r_valid;
    assign dma_req_addr  = r_addr;
    assign dma_req_rw    = r_rw;
    assign dma_req_wdata = r_wdata;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: switch to WRITE when the FIFO fills or the source is exhausted,
    // back to READ when the FIFO drains with words still to fetch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_state_next = (cfg_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (w_ack && ((r_count == CNT_W'(FIFO_DEPTH - 1)) ||
                              (r_rd_left == LEN_W'(1)))) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_ack) begin
                    if (r_wr_left == LEN_W'(1)) begin
                        w_state_next = S_DONE;
                    end else if (r_count == CNT_W'(1)) begin
                        w_state_next = S_READ;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Address pointers, remaining counts and progress counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_rd_left    <= '0;
            r_wr_left    <= '0;
            r_words_done <= '0;
        end else if (w_start) begin
            r_rd_ptr     <= cfg_src;
            r_wr_ptr     <= cfg_dst;
            r_rd_left    <= cfg_len;
            r_wr_left    <= cfg_len;
            r_words_done <= '0;
        end else begin
            if (w_push) begin
                r_rd_ptr  <= r_rd_ptr + 23'd1;
                r_rd_left <= r_rd_left - LEN_W'(1);
            end
            if (w_pop) begin
                r_wr_ptr     <= r_wr_ptr + 23'd1;
                r_wr_left    <= r_wr_left - LEN_W'(1);
                r_words_done <= r_words_done + LEN_W'(1);
            end
        end
    end

    // Registered request fields; the first read goes out on the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
        end else if (w_start) begin
            if (cfg_len != '0) begin
                r_valid <= 1'b1;
                r_addr  <= cfg_src;
                r_rw    <= 1'b0;
            end
        end else if (w_ack) begin
            r_valid <= 1'b0;
        end else if (w_issue) begin
            r_valid <= 1'b1;
            if (r_state == S_READ) begin
                r_addr <= r_rd_ptr;
                r_rw   <= 1'b0;
            end else begin
                r_addr  <= r_wr_ptr;
                r_rw    <= 1'b1;
                r_wdata <= r_fifo[r_head];
            end
        end
    end

    // FIFO pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_tail] <= dma_rsp_rdata;
        end
    end

    // Bursts are sized so the FIFO can never overflow or underflow.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_push && (r_count == CNT_W'(FIFO_DEPTH))));
            assert (!(w_pop && (r_count == '0)));
        end
    end

endmodule

// File: tb/tb_sdram_copy_dma.sv
// Bench for sdram_copy_dma: acts as the SDRAM arbiter with a sparse memory,
// and predicts the exact request stream from a chunked-copy model.
module tb_sdram_copy_dma;

    localparam int DEPTH = 4;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_start = 1'b0;
    logic [22:0]      cfg_src = '0;
    logic [22:0]      cfg_dst = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_done;
    logic             dma_req_valid;
    logic [22:0]      dma_req_addr;
    logic             dma_req_rw;
    logic [31:0]      dma_req_wdata;
    logic             dma_req_ack = 1'b0;
    logic [31:0]      dma_rsp_rdata = '0;

    int total = 0;
    int bad = 0;

    logic [31:0] sdram   [logic [22:0]];
    logic [31:0] ref_mem [logic [22:0]];
    logic [55:0] exp_q[$];

    sdram_copy_dma #(.FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
        .busy(busy), .done(done), .words_done(words_done),
        .dma_req_valid(dma_req_valid), .dma_req_addr(dma_req_addr),
        .dma_req_rw(dma_req_rw), .dma_req_wdata(dma_req_wdata),
        .dma_req_ack(dma_req_ack), .dma_rsp_rdata(dma_rsp_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(input logic [22:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mem_get(input logic [22:0] a);
        if (sdram.exists(a)) return sdram[a];
        return seed_word(a);
    endfunction

    function automatic logic [31:0] ref_get(input logic [22:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return seed_word(a);
    endfunction

    // Copy model: chunks of DEPTH words, read all then write all, ascending.
    // Each entry is {rw, addr, data}.
    function automatic void build_expected(input logic [22:0] src, input logic [22:0] dst,
                                           input int len);
        int rd;
        int n;
        logic [22:0] a;
        logic [31:0] d;
        logic [31:0] chunk[$];
        rd = 0;
        while (rd < len) begin
            n = len - rd;
            if (n > DEPTH) n = DEPTH;
            chunk.delete();
            for (int i = 0; i < n; i++) begin
                a = src + 23'(rd + i);
                d = ref_get(a);
                chunk.push_back(d);
                exp_q.push_back({1'b0, a, d});
            end
            for (int i = 0; i < n; i++) begin
                a = dst + 23'(rd + i);
                ref_mem[a] = chunk[i];
                exp_q.push_back({1'b1, a, chunk[i]});
            end
            rd += n;
        end
    endfunction

    // Start one copy at the current negedge and play arbiter until done.
    // stall_w: index of the write held off for 20 cycles (with a start pulse inside).
    // rst_w: index of the write during which reset is asserted (transfer aborted).
    task automatic run_copy(input logic [22:0] src, input logic [22:0] dst, input int len,
                            input int min_lat, input int max_lat,
                            input int stall_w, input int rst_w);
        int cyc, waitc, lat, ph, wr_idx, wr_acked;
        bit holding, ack_now, finished, aborted, is_stall;
        logic [55:0] e;
        logic [55:0] held;
        exp_q.delete();
        build_expected(src, dst, len);
        cfg_src = src;
        cfg_dst = dst;
        cfg_len = LEN_W'(len);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy);
        if (busy !== 1'b1) bad++;
        total++;
        if (len == 0) begin
            if (done !== 1'b1 || dma_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL zero_len_t1: done=%b valid=%b want done=1 valid=0", done, dma_req_valid);
            end
        end else begin
            if (dma_req_valid !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL first_valid: valid=%b done=%b want valid=1 done=0", dma_req_valid, done);
            end
        end
        holding = 0; ph = 0; wr_idx = 0; wr_acked = 0; finished = 0; aborted = 0;
        is_stall = 0; cyc = 0; waitc = 0; lat = 0; held = '0;
        while (!finished && cyc < 3000) begin
            ack_now = 0;
            cfg_start = 1'b0;
            if (ph == 1) begin
                total++;
                if (dma_req_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL gap_low: valid=%b want 0 in cycle after ack", dma_req_valid);
                end
                total++;
                if (words_done !== LEN_W'(wr_acked)) begin
                    bad++;
                    $display("FAIL words_done: got %0d want %0d", words_done, wr_acked);
                end
                ph = 2;
            end else if (ph == 2) begin
                if (exp_q.size() > 0) begin
                    total++;
                    if (dma_req_valid !== 1'b1) begin
                        bad++;
                        $display("FAIL next_valid: valid=%b want 1 two cycles after ack", dma_req_valid);
                    end
                end
                ph = 0;
            end
            if (dma_req_valid === 1'b1) begin
                if (!holding) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_req: rw=%b addr=%h with no request expected",
                                 dma_req_rw, dma_req_addr);
                        finished = 1;
                    end else begin
                        e = exp_q.pop_front();
                        if (dma_req_rw !== e[55] || dma_req_addr !== e[54:32] ||
                            (e[55] && dma_req_wdata !== e[31:0])) begin
                            bad++;
                            $display("FAIL request: got rw=%b addr=%h wdata=%h want rw=%b addr=%h wdata=%h",
                                     dma_req_rw, dma_req_addr, dma_req_wdata, e[55], e[54:32], e[31:0]);
                        end
                        holding = 1;
                        held = {dma_req_rw, dma_req_addr, dma_req_wdata};
                        waitc = 0;
                        lat = $urandom_range(max_lat, min_lat);
                        is_stall = 0;
                        if (e[55]) begin
                            if (wr_idx == stall_w) begin
                                lat = 20;
                                is_stall = 1;
                            end
                            if (wr_idx == rst_w) begin
                                rst_n = 1'b0;
                                #1;
                                total++;
                                if ({busy, done, words_done, dma_req_valid, dma_req_addr, dma_req_rw,
                                     dma_req_wdata} !== '0) begin
                                    bad++;
                                    $display("FAIL async_reset: busy=%b done=%b wd=%0d valid=%b addr=%h rw=%b wdata=%h want all 0",
                                             busy, done, words_done, dma_req_valid, dma_req_addr,
                                             dma_req_rw, dma_req_wdata);
                                end
                                aborted = 1;
                                finished = 1;
                            end
                            wr_idx++;
                        end
                    end
                end else begin
                    total++;
                    if ({dma_req_rw, dma_req_addr, dma_req_wdata} !== held) begin
                        bad++;
                        $display("FAIL req_stable: got %h want %h",
                                 {dma_req_rw, dma_req_addr, dma_req_wdata}, held);
                    end
                    if (is_stall && waitc == 5) begin
                        cfg_src = 23'h055555;
                        cfg_dst = 23'h066666;
                        cfg_len = LEN_W'(7);
                        cfg_start = 1'b1;
                    end
                end
                if (holding && !aborted) begin
                    if (waitc >= lat) begin
                        ack_now = 1;
                        if (held[55]) begin
                            sdram[held[54:32]] = held[31:0];
                            wr_acked++;
                        end else begin
                            dma_rsp_rdata = mem_get(held[54:32]);
                        end
                        holding = 0;
                        ph = 1;
                    end else begin
                        waitc++;
                    end
                end
            end
            if (!ack_now) dma_rsp_rdata = $urandom;
            if (!finished && done === 1'b1) begin
                total++;
                if (exp_q.size() != 0 || holding || busy !== 1'b1 || words_done !== LEN_W'(len)) begin
                    bad++;
                    $display("FAIL done_state: left=%0d busy=%b words_done=%0d want left=0 busy=1 words_done=%0d",
                             exp_q.size(), busy, words_done, len);
                end
                finished = 1;
            end
            dma_req_ack = ack_now;
            if (aborted) break;
            @(negedge clk);
            cyc++;
        end
        dma_req_ack = 1'b0;
        cfg_start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b1;
            exp_q.delete();
            ref_mem = sdram;
            @(negedge clk);
            return;
        end
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL timeout: no done within 3000 cycles, %0d requests left", exp_q.size());
        end else if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL after_done: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if (dma_req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL idle: valid=%b busy=%b done=%b want 0 0 0", dma_req_valid, busy, done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, words_done, dma_req_valid, dma_req_addr, dma_req_rw, dma_req_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_values: busy=%b done=%b wd=%0d valid=%b addr=%h rw=%b wdata=%h want all 0",
                     busy, done, words_done, dma_req_valid, dma_req_addr, dma_req_rw, dma_req_wdata);
        end
        rst_n = 1'b1;
        idle_check(2);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            sdram[23'h000100 + 23'(i)]   = 32'hA0 + 32'(i);
            ref_mem[23'h000100 + 23'(i)] = 32'hA0 + 32'(i);
        end
        run_copy(23'h000100, 23'h000200, 3, 2, 2, -1, -1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mem_get(23'h000200 + 23'(i)) !== 32'hA0 + 32'(i)) begin
                bad++;
                $display("FAIL basic_mem[%0d]: got %h want %h", i, mem_get(23'h000200 + 23'(i)),
                         32'hA0 + 32'(i));
            end
        end
        idle_check(2);
    endtask

    task automatic test_chunking();
        run_copy(23'h001000, 23'h002000, 10, 0, 3, -1, -1);
        idle_check(2);
    endtask

    task automatic test_zero_len();
        run_copy(23'h003000, 23'h004000, 0, 0, 0, -1, -1);
        idle_check(5);
    endtask

    task automatic test_wrap();
        run_copy(23'h7FFFFE, 23'h7FFFFF, 3, 0, 2, -1, -1);
        total++;
        if (mem_get(23'h000001) !== seed_word(23'h000000)) begin
            bad++;
            $display("FAIL wrap_mem: got %h want %h", mem_get(23'h000001), seed_word(23'h000000));
        end
        idle_check(2);
    endtask

    task automatic test_stall_ignore();
        run_copy(23'h005000, 23'h006000, 6, 1, 2, 1, -1);
        idle_check(8);
    endtask

    task automatic test_reset_mid_write();
        run_copy(23'h007000, 23'h008000, 6, 3, 3, -1, 1);
        idle_check(2);
        run_copy(23'h009000, 23'h00A000, 2, 0, 2, -1, -1);
        idle_check(2);
    endtask

    task automatic test_back_to_back();
        run_copy(23'h00B000, 23'h00C000, 5, 0, 1, -1, -1);
        run_copy(23'h00C000, 23'h00D000, 4, 0, 1, -1, -1);
        idle_check(2);
    endtask

    task automatic test_random();
        logic [22:0] src;
        logic [22:0] dst;
        int len;
        for (int k = 0; k < 8; k++) begin
            src = 23'($urandom_range(32'h7F0000, 32'h010000));
            if ($urandom_range(1, 0) == 1) dst = src - 23'($urandom_range(40, 0));
            else dst = src + 23'($urandom_range(4000, 100));
            len = $urandom_range(20, 1);
            run_copy(src, dst, len, 0, 3, -1, -1);
            idle_check(1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chunking();
        test_zero_len();
        test_wrap();
        test_stall_ignore();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
